// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage controller: FSM encoding,
// the MEM/WB field bundle and the bubble helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [31:0] BUBBLE_PC_DEF = 32'hFFFF_FFFF;
  localparam int unsigned TIMEOUT_DEF   = 16;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [31:0] data;
    logic [3:0]  dest;
    logic [31:0] pc;
  } mem_wb_t;

  // A bubble keeps data/dest from the previous contents so they do not toggle.
  function automatic mem_wb_t bubble_of(input mem_wb_t prev, input logic [31:0] bubble_pc);
    mem_wb_t b;
    b           = prev;
    b.valid     = 1'b0;
    b.reg_write = 1'b0;
    b.pc        = bubble_pc;
    return b;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the MEM-stage controller and memory.
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_err;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_err, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_err, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl_access_timer.sv
// Counts ACCESS cycles; expired flags the last cycle allowed before a timeout.
module access_timer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_r;

  // Clear on issue, count up while the access is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (inc) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory accesses, stalls upstream while they
// are outstanding, drives the MEM/WB register and latches sticky faults.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter logic [31:0] BUBBLE_PC = BUBBLE_PC_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    reg_write,
  input  logic                    wb_sel,
  input  logic [31:0]             alu_result,
  input  logic [31:0]             store_data,
  input  logic [3:0]              dest_reg,
  input  logic [31:0]             pc,
  mem_stage_ctrl_if.master        dmem,
  output logic                    stall,
  output logic                    wb_valid,
  output logic                    wb_reg_write,
  output logic [31:0]             wb_data,
  output logic [3:0]              wb_dest,
  output logic [31:0]             wb_pc,
  output logic                    fault,
  output logic [31:0]             fault_pc
);

  state_t      state_r, next_state_s;
  logic        req_r, we_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  lat_dest_r;
  logic        lat_reg_write_r, lat_wb_sel_r;
  logic [31:0] lat_pc_r;
  mem_wb_t     wb_r, wb_next_s;
  logic        fault_r;
  logic [31:0] fault_pc_r;

  logic slot_valid_s, mem_op_s, done_ok_s, done_err_s, expired_s;
  logic issue_s, finish_s, set_fault_s, timer_clr_s, timer_inc_s, stall_s;

  assign slot_valid_s = (pc != BUBBLE_PC);
  assign mem_op_s     = slot_valid_s & (mem_read | mem_write);
  assign done_ok_s    = dmem.dmem_ready & ~dmem.dmem_err;
  assign done_err_s   = dmem.dmem_ready & dmem.dmem_err;

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr_s),
    .inc     (timer_inc_s),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state, stall and the value headed into MEM/WB.
  always_comb begin
    next_state_s = state_r;
    wb_next_s    = bubble_of(wb_r, BUBBLE_PC);
    stall_s      = 1'b0;
    issue_s      = 1'b0;
    finish_s     = 1'b0;
    set_fault_s  = 1'b0;
    timer_clr_s  = 1'b0;
    timer_inc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_op_s) begin
          issue_s      = 1'b1;
          timer_clr_s  = 1'b1;
          stall_s      = 1'b1;
          next_state_s = ST_ACCESS;
        end else if (slot_valid_s) begin
          wb_next_s.valid     = 1'b1;
          wb_next_s.reg_write = reg_write;
          wb_next_s.data      = alu_result;
          wb_next_s.dest      = dest_reg;
          wb_next_s.pc        = pc;
        end else begin
          wb_next_s = bubble_of(wb_r, BUBBLE_PC);
        end
      end
      ST_ACCESS: begin
        timer_inc_s = 1'b1;
        if (done_ok_s) begin
          finish_s            = 1'b1;
          next_state_s        = ST_IDLE;
          wb_next_s.valid     = 1'b1;
          wb_next_s.reg_write = lat_reg_write_r & ~we_r;
          wb_next_s.data      = lat_wb_sel_r ? dmem.dmem_rdata : addr_r;
          wb_next_s.dest      = lat_dest_r;
          wb_next_s.pc        = lat_pc_r;
        end else if (done_err_s | expired_s) begin
          set_fault_s  = 1'b1;
          stall_s      = 1'b1;
          next_state_s = ST_FAULT;
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_FAULT: begin
        stall_s = 1'b1;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Bus request and the instruction fields captured at issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_r           <= 1'b0;
      we_r            <= 1'b0;
      addr_r          <= 32'd0;
      wdata_r         <= 32'd0;
      lat_dest_r      <= 4'd0;
      lat_reg_write_r <= 1'b0;
      lat_wb_sel_r    <= 1'b0;
      lat_pc_r        <= 32'd0;
    end else if (issue_s) begin
      req_r           <= 1'b1;
      we_r            <= mem_write & ~mem_read;
      addr_r          <= alu_result;
      wdata_r         <= store_data;
      lat_dest_r      <= dest_reg;
      lat_reg_write_r <= reg_write;
      lat_wb_sel_r    <= wb_sel;
      lat_pc_r        <= pc;
    end else if (finish_s | set_fault_s) begin
      req_r <= 1'b0;
    end else begin
      req_r <= req_r;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_r <= '{valid: 1'b0, reg_write: 1'b0, data: 32'd0, dest: 4'd0, pc: BUBBLE_PC};
    end else begin
      wb_r <= wb_next_s;
    end
  end

  // Sticky fault record; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_r    <= 1'b0;
      fault_pc_r <= 32'd0;
    end else if (set_fault_s) begin
      fault_r    <= 1'b1;
      fault_pc_r <= lat_pc_r;
    end else begin
      fault_r    <= fault_r;
      fault_pc_r <= fault_pc_r;
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;

  assign stall        = reset_n & stall_s;
  assign wb_valid     = wb_r.valid;
  assign wb_reg_write = wb_r.reg_write;
  assign wb_data      = wb_r.data;
  assign wb_dest      = wb_r.dest;
  assign wb_pc        = wb_r.pc;
  assign fault        = fault_r;
  assign fault_pc     = fault_pc_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random instruction streams,
// checked every cycle against a per-instruction timeline model.
module tb_mem_stage_ctrl;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] BPC = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write, reg_write, wb_sel;
  logic [31:0] alu_result, store_data, pc;
  logic [3:0]  dest_reg;
  logic        stall, wb_valid, wb_reg_write, fault;
  logic [31:0] wb_data, wb_pc, fault_pc;
  logic [3:0]  wb_dest;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(TMO), .BUBBLE_PC(BPC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .dest_reg     (dest_reg),
    .pc           (pc),
    .dmem         (bus),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .wb_pc        (wb_pc),
    .fault        (fault),
    .fault_pc     (fault_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, rw, sel;
    logic [31:0] alu, sdata;
    logic [3:0]  dest;
    logic [31:0] pc;
    int          lat;    // ACCESS cycle (1-based) that sees ready; 0 = never
    logic        err;
    logic [31:0] rdata;
  } op_t;

  int n_pass = 0, n_total = 0;
  int obs_req = 0, obs_stall = 0;

  // Model of what MEM/WB and fault outputs currently show
  logic        m_valid, m_rw, m_fault;
  logic [31:0] m_data, m_pc, m_fpc;
  logic [3:0]  m_dest;

  // Expectations for the cycle being driven
  logic        check_en = 1'b0;
  logic        e_stall, e_req, e_we;
  logic [31:0] e_addr, e_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    #2;
    if (check_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("dmem_req", {31'd0, bus.dmem_req}, {31'd0, e_req});
      if (e_req) begin
        chk("dmem_addr", bus.dmem_addr, e_addr);
        chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, e_we});
        chk("dmem_wdata", bus.dmem_wdata, e_wdata);
      end
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, m_rw});
      chk("wb_data", wb_data, m_data);
      chk("wb_dest", {28'd0, wb_dest}, {28'd0, m_dest});
      chk("wb_pc", wb_pc, m_pc);
      chk("fault", {31'd0, fault}, {31'd0, m_fault});
      chk("fault_pc", fault_pc, m_fpc);
      obs_req   += int'(bus.dmem_req);
      obs_stall += int'(stall);
    end
  end

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_data = 32'd0; m_dest = 4'd0;
    m_pc = BPC; m_fault = 1'b0; m_fpc = 32'd0;
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_rw = 1'b0; m_pc = BPC;
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    reset_n  = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; wb_sel = 1'b1;
    alu_result = 32'h1234; store_data = 32'h5678; dest_reg = 4'd3; pc = 32'h40;
    bus.dmem_ready = 1'b1; bus.dmem_err = 1'b0; bus.dmem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_dest", {28'd0, wb_dest}, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'hFFFF_FFFF);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    model_reset();
    pc      = BPC;
    reset_n = 1'b1;
  endtask

  // Present one instruction for as long as the pipeline would hold it.
  task automatic run_op(input op_t o, input int abort_at);
    bit mem;
    int p;
    mem = (o.pc != BPC) && (o.rd || o.wr);
    if (m_fault || !mem) p = 1;
    else p = (o.lat == 0) ? int'(TMO) + 1 : o.lat + 1;
    for (int k = 0; k < p; k++) begin
      @(negedge clk);
      mem_read = o.rd; mem_write = o.wr; reg_write = o.rw; wb_sel = o.sel;
      alu_result = o.alu; store_data = o.sdata; dest_reg = o.dest; pc = o.pc;
      if (!m_fault && mem && k >= 1 && k == o.lat) begin
        bus.dmem_ready = 1'b1; bus.dmem_err = o.err; bus.dmem_rdata = o.rdata;
      end else if (!m_fault && mem && k >= 1) begin
        bus.dmem_ready = 1'b0; bus.dmem_err = 1'($urandom); bus.dmem_rdata = $urandom;
      end else begin
        bus.dmem_ready = 1'($urandom); bus.dmem_err = 1'($urandom); bus.dmem_rdata = $urandom;
      end
      e_req   = !m_fault && mem && k >= 1;
      e_addr  = o.alu;
      e_we    = o.wr & ~o.rd;
      e_wdata = o.sdata;
      if (m_fault) e_stall = 1'b1;
      else if (!mem) e_stall = 1'b0;
      else e_stall = !(k >= 1 && k == o.lat && !o.err);
      check_en = 1'b1;
      if (abort_at > 0 && k == abort_at) begin
        #3;
        check_en = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("abort_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_wb_pc", wb_pc, 32'hFFFF_FFFF);
        chk("abort_addr", bus.dmem_addr, 32'd0);
        chk("abort_fault", {31'd0, fault}, 32'd0);
        model_reset();
        return;
      end
      @(posedge clk);
      if (!m_fault) begin
        if (!mem) begin
          if (o.pc != BPC) begin
            m_valid = 1'b1; m_rw = o.rw; m_data = o.alu; m_dest = o.dest; m_pc = o.pc;
          end else begin
            model_bubble();
          end
        end else if (k < p - 1) begin
          model_bubble();
        end else if (o.lat != 0 && !o.err) begin
          m_valid = 1'b1;
          m_rw    = o.rw & ~(o.wr & ~o.rd);
          m_data  = o.sel ? o.rdata : o.alu;
          m_dest  = o.dest;
          m_pc    = o.pc;
        end else begin
          model_bubble();
          m_fault = 1'b1;
          m_fpc   = o.pc;
        end
      end
    end
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic rw, input logic sel,
                             input logic [31:0] alu, input logic [31:0] sdata, input logic [3:0] dest,
                             input logic [31:0] opc, input int lat, input logic err,
                             input logic [31:0] rdata);
    op_t o;
    o.rd = rd; o.wr = wr; o.rw = rw; o.sel = sel; o.alu = alu; o.sdata = sdata;
    o.dest = dest; o.pc = opc; o.lat = lat; o.err = err; o.rdata = rdata;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.rd    = ($urandom_range(0, 99) < 35);
    o.wr    = ($urandom_range(0, 99) < 25);
    o.rw    = 1'($urandom);
    o.sel   = 1'($urandom);
    o.alu   = $urandom;
    o.sdata = $urandom;
    o.dest  = 4'($urandom);
    o.pc    = $urandom;
    if ($urandom_range(0, 99) < 12) o.pc = BPC;
    else if (o.pc == BPC) o.pc = 32'd0;
    o.lat   = ($urandom_range(0, 99) < 4) ? 0 : int'($urandom_range(1, TMO));
    o.err   = ($urandom_range(0, 99) < 3);
    o.rdata = $urandom;
    return o;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dmem_ready = 1'b0; bus.dmem_err = 1'b0; bus.dmem_rdata = 32'd0;
    do_reset();

    // ALU pass-through
    obs_stall = 0;
    run_op(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 4'd2, 32'h10, 1, 1'b0, 32'h0), 0);
    #2;
    chk("pt_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("pt_wb_data", wb_data, 32'h55);
    chk("pt_stall_cycles", obs_stall, 0);

    // Load answered in the third ACCESS cycle
    obs_req = 0; obs_stall = 0;
    run_op(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 4'd5, 32'h14, 3, 1'b0, 32'hDEADBEEF), 0);
    #2;
    chk("ld_req_cycles", obs_req, 3);
    chk("ld_stall_cycles", obs_stall, 3);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_dest", {28'd0, wb_dest}, 32'd5);

    // Back-to-back stores with immediate ready
    obs_req = 0; obs_stall = 0;
    run_op(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h1111, 4'd6, 32'h18, 1, 1'b0, 32'h0), 0);
    #2;
    chk("st1_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    run_op(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h2222, 4'd7, 32'h1C, 1, 1'b0, 32'h0), 0);
    #2;
    chk("st2_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("st_req_cycles", obs_req, 2);
    chk("st_stall_cycles", obs_stall, 2);

    // Empty slot carrying mem_read
    obs_req = 0; obs_stall = 0;
    run_op(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 4'd1, BPC, 1, 1'b0, 32'h0), 0);
    #2;
    chk("bub_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("bub_req_cycles", obs_req, 0);
    chk("bub_stall_cycles", obs_stall, 0);

    // Bus error
    run_op(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h90, 32'h0, 4'd4, 32'h200, 2, 1'b1, 32'h0), 0);
    #2;
    chk("err_fault", {31'd0, fault}, 32'd1);
    chk("err_fault_pc", fault_pc, 32'h200);
    do_reset();

    // Timeout, then later ready ignored
    obs_req = 0;
    run_op(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 32'h0, 4'd8, 32'h300, 0, 1'b0, 32'h0), 0);
    #2;
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_fault_pc", fault_pc, 32'h300);
    chk("to_req_cycles", obs_req, 4);
    for (int i = 0; i < 3; i++) run_op(rand_op(), 0);
    do_reset();

    // Reset pulse in the middle of an access
    run_op(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 32'h0, 4'd9, 32'h400, 3, 1'b0, 32'h0), 2);
    do_reset();

    // Random instruction streams
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int n = 0; n < 40; n++) run_op(rand_op(), 0);
    end

    check_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
